// File: rtl/cordic_issue.sv
// Issue stage in front of the pipelined CORDIC rotator: folds the phase into
// [-pi/2, pi/2), converts it to Q2.30 radians and tracks results by tag.
module cordic_issue #(
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned CORDIC_LAT = 16,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_x,
  input  logic signed [BIT_WIDTH-1:0] in_y,
  input  logic        [31:0]          in_phase,
  input  logic        [TAG_W-1:0]     in_tag,
  output logic signed [BIT_WIDTH-1:0] cordic_x,
  output logic signed [BIT_WIDTH-1:0] cordic_y,
  output logic signed [31:0]          cordic_angle,
  output logic                        res_valid,
  output logic        [TAG_W-1:0]     res_tag,
  input  logic                        slot_free,
  output logic                        busy
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic signed [63:0] HALF_PI_Q30 = 64'sd1686629713;
  localparam logic signed [63:0] ROUND_Q30   = 64'sd536870912;
  localparam logic signed [BIT_WIDTH-1:0] SMIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic signed [BIT_WIDTH-1:0] SMAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  function automatic logic signed [BIT_WIDTH-1:0] sat_neg(input logic signed [BIT_WIDTH-1:0] v);
    if (v == SMIN) return SMAX;
    return -v;
  endfunction

  logic [CW-1:0]                credits_q, credits_d;
  logic                         acc;
  logic                         flip;
  logic                         s1_v_q;
  logic        [TAG_W-1:0]      s1_tag_q;
  logic signed [BIT_WIDTH-1:0]  s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic signed [31:0]           s1_r_q, s1_r_d;
  logic                         s2_v_q;
  logic        [TAG_W-1:0]      s2_tag_q;
  logic signed [BIT_WIDTH-1:0]  cx_q, cy_q;
  logic signed [31:0]           ca_q, ca_d;
  logic signed [63:0]           prod;
  logic        [CORDIC_LAT-1:0] dl_v_q;
  logic        [TAG_W-1:0]      dl_tag_q [CORDIC_LAT];
  logic                         busy_q, busy_d;

  assign in_ready     = !rst && (credits_q != '0);
  assign cordic_x     = cx_q;
  assign cordic_y     = cy_q;
  assign cordic_angle = ca_q;
  assign res_valid    = dl_v_q[CORDIC_LAT-1];
  assign res_tag      = dl_tag_q[CORDIC_LAT-1];
  assign busy         = busy_q;

  // Credit accounting, phase fold and radian conversion
  always_comb begin
    acc       = in_valid && in_ready;
    credits_d = credits_q;
    if (acc && !slot_free)
      credits_d = credits_q - CW'(1);
    else if (!acc && slot_free && (credits_q != CREDITS_MAX))
      credits_d = credits_q + CW'(1);

    // Quadrants 1 and 2 are rotated by pi so the residual stays within +-pi/2
    flip   = in_phase[31] ^ in_phase[30];
    s1_x_d = flip ? sat_neg(in_x) : in_x;
    s1_y_d = flip ? sat_neg(in_y) : in_y;
    s1_r_d = {in_phase[31] ^ flip, in_phase[30:0]};

    prod   = 64'(s1_r_q) * HALF_PI_Q30 + ROUND_Q30;
    ca_d   = 32'(prod >>> 30);

    busy_d = acc | s1_v_q | s2_v_q | (|dl_v_q[CORDIC_LAT-2:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CREDITS_MAX;
      s1_v_q    <= 1'b0;
      s1_tag_q  <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_r_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_tag_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      ca_q      <= '0;
      dl_v_q    <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < int'(CORDIC_LAT); i++) dl_tag_q[i] <= '0;
    end else begin
      credits_q <= credits_d;
      busy_q    <= busy_d;
      s1_v_q    <= acc;
      if (acc) begin
        s1_tag_q <= in_tag;
        s1_x_q   <= s1_x_d;
        s1_y_q   <= s1_y_d;
        s1_r_q   <= s1_r_d;
      end
      s2_v_q   <= s1_v_q;
      s2_tag_q <= s1_tag_q;
      if (s1_v_q) begin
        cx_q <= s1_x_q;
        cy_q <= s1_y_q;
        ca_q <= ca_d;
      end
      // Valid/tag line mirrors the rotator latency from the moment its inputs change
      dl_v_q      <= {dl_v_q[CORDIC_LAT-2:0], s2_v_q};
      dl_tag_q[0] <= s2_tag_q;
      for (int i = 1; i < int'(CORDIC_LAT); i++) dl_tag_q[i] <= dl_tag_q[i-1];
    end
  end

endmodule

// File: tb/tb_cordic_issue.sv
// Bench for cordic_issue: vector table, credit/ordering/reset sequences and
// random traffic compared against an arithmetic reference model.
module tb_cordic_issue;
  localparam int BW  = 8;
  localparam int LAT = 16;
  localparam int TW  = 4;
  localparam int CR  = 4;
  localparam longint C_HP  = 64'sd1686629713;
  localparam longint TWO29 = 64'sd536870912;
  localparam longint TWO30 = 64'sd1073741824;
  localparam longint TWO31 = 64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, slot_free = 1'b0;
  logic signed [BW-1:0] in_x = '0, in_y = '0;
  logic [31:0] in_phase = '0;
  logic [TW-1:0] in_tag = '0;
  logic signed [BW-1:0] cordic_x, cordic_y;
  logic signed [31:0] cordic_angle;
  logic res_valid, busy;
  logic [TW-1:0] res_tag;

  always #5 clk = ~clk;

  cordic_issue #(.BIT_WIDTH(BW), .CORDIC_LAT(LAT), .TAG_W(TW), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_phase(in_phase), .in_tag(in_tag),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_angle(cordic_angle),
    .res_valid(res_valid), .res_tag(res_tag), .slot_free(slot_free), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int credits_m = CR;
  bit pend_v = 1'b0;
  longint pend_x, pend_y, pend_a;
  longint cx_m = 0, cy_m = 0, ca_m = 0;
  int acc_q[$];
  bit exp_v[int];
  logic [TW-1:0] exp_tag[int];

  typedef struct {
    logic signed [BW-1:0] x, y;
    logic [31:0] ph;
    logic [TW-1:0] tag;
    longint ex, ey, ea;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: signed turn fraction, fold by +-pi, scale to radians with round-half-up
  function automatic void fold(input logic signed [BW-1:0] x, input logic signed [BW-1:0] y,
                               input logic [31:0] ph,
                               output longint fx, output longint fy, output longint fa);
    longint p;
    bit neg;
    p   = longint'(ph);
    neg = 1'b0;
    if (p >= TWO31) p = p - TWO32;
    if (p >= TWO30) begin p = p - TWO31; neg = 1'b1; end
    else if (p < -TWO30) begin p = p + TWO31; neg = 1'b1; end
    fa = (p * C_HP + TWO29) >>> 30;
    fx = neg ? -longint'(x) : longint'(x);
    fy = neg ? -longint'(y) : longint'(y);
    if (fx > 127) fx = 127;
    if (fy > 127) fy = 127;
  endfunction

  task automatic cycle(input bit v, input logic signed [BW-1:0] x, input logic signed [BW-1:0] y,
                       input logic [31:0] ph, input logic [TW-1:0] tag, input bit sf);
    bit acc;
    longint fx, fy, fa;
    in_valid = v; in_x = x; in_y = y; in_phase = ph; in_tag = tag; slot_free = sf;
    #1;
    chk("in_ready", longint'(in_ready), longint'(credits_m != 0));
    acc = v && (credits_m != 0);
    @(posedge clk);
    cyc++;
    if (pend_v) begin cx_m = pend_x; cy_m = pend_y; ca_m = pend_a; end
    pend_v = acc;
    if (acc) begin
      fold(x, y, ph, fx, fy, fa);
      pend_x = fx; pend_y = fy; pend_a = fa;
      exp_v[cyc + LAT + 1]   = 1'b1;
      exp_tag[cyc + LAT + 1] = tag;
      acc_q.push_back(cyc);
    end
    if (acc && !sf) credits_m--;
    else if (!acc && sf && credits_m < CR) credits_m++;
    @(negedge clk);
    chk("cordic_x", longint'(cordic_x), cx_m);
    chk("cordic_y", longint'(cordic_y), cy_m);
    chk("cordic_angle", longint'(cordic_angle), ca_m);
    chk("res_valid", longint'(res_valid), longint'(exp_v.exists(cyc)));
    if (exp_v.exists(cyc)) chk("res_tag", longint'(res_tag), longint'(exp_tag[cyc]));
    while (acc_q.size() > 0 && acc_q[0] + LAT + 1 < cyc) void'(acc_q.pop_front());
    chk("busy", longint'(busy), longint'(acc_q.size() > 0));
  endtask

  task automatic idle(input int n, input bit sf);
    repeat (n) cycle(1'b0, '0, '0, '0, '0, sf);
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0; slot_free = 1'b0; rst = 1'b1;
    #1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_res_tag", longint'(res_tag), 0);
    chk("rst_cordic_x", longint'(cordic_x), 0);
    chk("rst_cordic_y", longint'(cordic_y), 0);
    chk("rst_cordic_angle", longint'(cordic_angle), 0);
    rst = 1'b0;
    cyc = 0; credits_m = CR; pend_v = 1'b0;
    cx_m = 0; cy_m = 0; ca_m = 0;
    acc_q.delete(); exp_v.delete(); exp_tag.delete();
  endtask

  initial begin
    tbl[0] = '{x:  64,  y:   0, ph: 32'h2000_0000, tag: 4'd3, ex:  64, ey:   0, ea:  843314857};
    tbl[1] = '{x:  64,  y:   0, ph: 32'hA000_0000, tag: 4'd4, ex: -64, ey:   0, ea:  843314857};
    tbl[2] = '{x:  10,  y:   5, ph: 32'h6000_0000, tag: 4'd5, ex: -10, ey:  -5, ea: -843314856};
    tbl[3] = '{x: -128, y: -128, ph: 32'h8000_0000, tag: 4'd6, ex: 127, ey: 127, ea: 0};
    tbl[4] = '{x: -128, y: -128, ph: 32'h4000_0000, tag: 4'd7, ex: 127, ey: 127, ea: -1686629713};
    tbl[5] = '{x:   5,  y:  -7, ph: 32'h0000_0000, tag: 4'd1, ex:   5, ey:  -7, ea: 0};
    tbl[6] = '{x:   3,  y:   4, ph: 32'hC000_0000, tag: 4'd2, ex:   3, ey:   4, ea: -1686629713};
    tbl[7] = '{x:   1,  y:   2, ph: 32'hFFFF_FFFF, tag: 4'd9, ex:   1, ey:   2, ea: -2};

    do_reset(3);

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].x, tbl[i].y, tbl[i].ph, tbl[i].tag, 1'b0);
      cycle(1'b0, '0, '0, '0, '0, 1'b1);
      chk("tbl_x", longint'(cordic_x), tbl[i].ex);
      chk("tbl_y", longint'(cordic_y), tbl[i].ey);
      chk("tbl_angle", longint'(cordic_angle), tbl[i].ea);
    end
    idle(20, 1'b0);

    // Credit exhaustion, single refill, accept+free together, saturation at full
    repeat (6) cycle(1'b1, 8'sd1, 8'sd1, 32'h1000_0000, 4'd8, 1'b0);
    chk("credit_stall", longint'(in_ready), 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1);
    chk("credit_refill", longint'(in_ready), 1);
    cycle(1'b1, 8'sd2, 8'sd2, 32'h3000_0000, 4'd9, 1'b0);
    chk("credit_stall2", longint'(in_ready), 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1);
    cycle(1'b1, 8'sd3, 8'sd3, 32'h5000_0000, 4'd10, 1'b1);
    chk("credit_acc_free", longint'(in_ready), 1);
    idle(6, 1'b1);
    repeat (6) cycle(1'b1, 8'sd4, -8'sd4, 32'h9000_0000, 4'd11, 1'b0);
    idle(20, 1'b1);

    // Back-to-back tags 1,2,3
    for (int t = 1; t <= 3; t++) cycle(1'b1, 8'sd7, 8'sd9, 32'h7000_0000, 4'(t), 1'b0);
    idle(LAT + 4, 1'b1);

    // Random traffic
    repeat (600) cycle(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), $urandom,
                       4'($urandom), ($urandom_range(0, 2) == 0));
    idle(LAT + 4, 1'b1);

    // Reset with requests in flight
    cycle(1'b1, 8'sd20, 8'sd30, 32'h2000_0000, 4'd12, 1'b0);
    cycle(1'b1, 8'sd21, 8'sd31, 32'hE000_0000, 4'd13, 1'b0);
    idle(5, 1'b0);
    do_reset(2);
    idle(LAT + 6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
